recebe_sequencia_movimentos: RTL and testbench

- Parametrised successor of the move-reception block.
- Fetches a complete solution sequence from the host PC. On `iniciar` it sends a request byte over its own 8N1 transmitter, then receives move bytes over its own 8N1 receiver, validates each byte, and writes each move into the move memory with explicit address and write-enable.
- Terminates on an end marker, a timeout, an invalid byte or memory overflow. Reports the move count, `pronto` and an error code to the top-level control unit.

---
 rtl/recebe_sequencia_movimentos.sv | 233 +++++++++++++++++++++++
 tb/tb_recebe_sequencia_movimentos.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recebe_sequencia_movimentos.sv
// Move-sequence reception block: requests a solution from the host over 8N1 serial,
// validates each received move byte and writes it into the move memory.
module recebe_sequencia_movimentos #(
    parameter int          CLKS_PER_BIT   = 434,
    parameter int          MOVE_WIDTH     = 4,
    parameter int          NUM_MOVES      = 12,
    parameter int          ADDR_WIDTH     = 6,
    parameter logic [7:0]  REQ_BYTE       = 8'h52,
    parameter logic [7:0]  END_BYTE       = 8'h46,
    parameter int          TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic                  rx_serial,
    output logic                  saida_serial,
    output logic [MOVE_WIDTH-1:0] movimento,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we_movimento,
    output logic [ADDR_WIDTH:0]   num_movimentos,
    output logic                  pronto,
    output logic                  erro,
    output logic [1:0]            codigo_erro,
    output logic [3:0]            db_estado
);

    localparam int                  CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int                  TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] MAX_MOVES = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [7:0]          MOVE_LIM  = 8'(NUM_MOVES);

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        ENVIA_PEDIDO = 4'd1,
        AGUARDA_TX   = 4'd2,
        ESPERA_BYTE  = 4'd3,
        VALIDA       = 4'd4,
        GRAVA        = 4'd5,
        INCREMENTA   = 4'd6,
        FIM_OK       = 4'd7,
        FIM_ERRO     = 4'd8
    } estado_t;

    estado_t         estado, estado_next;
    logic [1:0]      codigo_next;
    logic [TO_W-1:0] timeout_cnt;

    // Transmitter: 9-bit frame {stop, data}; the start bit is driven directly on launch.
    logic             tx_start, tx_busy, tx_done;
    logic [8:0]       tx_frame;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;

    assign tx_start = (estado == ENVIA_PEDIDO);

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_frame     <= '0;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            saida_serial <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            if (tx_start) begin
                tx_busy      <= 1'b1;
                tx_frame     <= {1'b1, REQ_BYTE};
                tx_cnt       <= '0;
                tx_bit       <= '0;
                saida_serial <= 1'b0;
            end else if (tx_busy) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_busy      <= 1'b0;
                        tx_done      <= 1'b1;
                        saida_serial <= 1'b1;
                    end else begin
                        saida_serial <= tx_frame[0];
                        tx_frame     <= {1'b1, tx_frame[8:1]};
                        tx_bit       <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
    // rx_bit 0 is the start-bit qualification, 1..8 data, 9 stop.
    logic             rx_meta, rx_sync, rx_prev;
    logic             rx_busy, rx_valid, rx_ferr;
    logic [7:0]       rx_data;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_data  <= '0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_meta  <= rx_serial;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= '0;
                    rx_cnt  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_sync) rx_busy <= 1'b0;  // glitch, not a real start bit
                    else         rx_bit  <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_busy  <= 1'b0;
                    rx_valid <= 1'b1;
                    rx_ferr  <= !rx_sync;
                end else begin
                    rx_data <= {rx_sync, rx_data[7:1]};
                    rx_bit  <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= estado_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise latches are inferred.
        estado_next = estado;
        codigo_next = 2'd0;
        case (estado)
            OCIOSO:       if (iniciar) estado_next = ENVIA_PEDIDO;
            ENVIA_PEDIDO: estado_next = AGUARDA_TX;
            AGUARDA_TX:   if (tx_done) estado_next = ESPERA_BYTE;
            ESPERA_BYTE: begin
                if (rx_valid) begin
                    estado_next = VALIDA;
                end else if (timeout_cnt == TO_LAST) begin
                    estado_next = FIM_ERRO;
                    codigo_next = 2'd3;
                end
            end
            VALIDA: begin
                if (rx_ferr) begin
                    estado_next = FIM_ERRO;
                    codigo_next = 2'd1;
                end else if (rx_data == END_BYTE) begin
                    estado_next = FIM_OK;
                end else if (rx_data >= MOVE_LIM) begin
                    estado_next = FIM_ERRO;
                    codigo_next = 2'd1;
                end else if (num_movimentos == MAX_MOVES) begin
                    estado_next = FIM_ERRO;
                    codigo_next = 2'd2;
                end else begin
                    estado_next = GRAVA;
                end
            end
            GRAVA:        estado_next = INCREMENTA;
            INCREMENTA:   estado_next = ESPERA_BYTE;
            FIM_OK:       estado_next = OCIOSO;
            FIM_ERRO:     estado_next = OCIOSO;
            default:      estado_next = OCIOSO;
        endcase
    end

    // Registered outputs: the write strobe lands the cycle after GRAVA, three cycles after the stop sample.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timeout_cnt    <= '0;
            movimento      <= '0;
            addr           <= '0;
            we_movimento   <= 1'b0;
            num_movimentos <= '0;
            pronto         <= 1'b0;
            erro           <= 1'b0;
            codigo_erro    <= 2'd0;
        end else begin
            we_movimento <= 1'b0;
            pronto       <= 1'b0;
            timeout_cnt  <= (estado == ESPERA_BYTE) ? timeout_cnt + TO_W'(1) : '0;
            case (estado)
                OCIOSO: if (iniciar) begin
                    num_movimentos <= '0;
                    addr           <= '0;
                    erro           <= 1'b0;
                    codigo_erro    <= 2'd0;
                end
                GRAVA: begin
                    movimento    <= rx_data[MOVE_WIDTH-1:0];
                    addr         <= num_movimentos[ADDR_WIDTH-1:0];
                    we_movimento <= 1'b1;
                end
                INCREMENTA: num_movimentos <= num_movimentos + (ADDR_WIDTH + 1)'(1);
                FIM_OK:     pronto <= 1'b1;
                default:    ;
            endcase
            if (estado_next == FIM_ERRO) begin
                erro        <= 1'b1;
                codigo_erro <= codigo_next;
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_recebe_sequencia_movimentos.sv
// Bench for recebe_sequencia_movimentos: directed host traffic, scoreboard queues of expected
// writes / completions / errors drained by a monitor that watches the DUT outputs.
module tb_recebe_sequencia_movimentos;

    localparam int CPB = 8;
    localparam int AW  = 2;
    localparam int MW  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic          rx_serial = 1'b1;
    logic          saida_serial;
    logic [MW-1:0] movimento;
    logic [AW-1:0] addr;
    logic          we_movimento;
    logic [AW:0]   num_movimentos;
    logic          pronto;
    logic          erro;
    logic [1:0]    codigo_erro;
    logic [3:0]    db_estado;

    recebe_sequencia_movimentos #(
        .CLKS_PER_BIT   (CPB),
        .MOVE_WIDTH     (MW),
        .NUM_MOVES      (12),
        .ADDR_WIDTH     (AW),
        .REQ_BYTE       (8'h52),
        .END_BYTE       (8'h46),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .rx_serial      (rx_serial),
        .saida_serial   (saida_serial),
        .movimento      (movimento),
        .addr           (addr),
        .we_movimento   (we_movimento),
        .num_movimentos (num_movimentos),
        .pronto         (pronto),
        .erro           (erro),
        .codigo_erro    (codigo_erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct { logic [AW-1:0] a; logic [MW-1:0] m; } wr_t;
    typedef struct { logic [1:0] code; int num; } err_t;

    wr_t  wr_q[$];
    int   pronto_q[$];
    err_t err_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [MW-1:0] m);
        wr_t e;
        e.a = a;
        e.m = m;
        wr_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code, input int num);
        err_t e;
        e.code = code;
        e.num  = num;
        err_q.push_back(e);
    endtask

    // Monitor: every strobe/pulse/error edge the DUT presents must match the head of its queue.
    logic erro_q = 1'b0;
    always @(negedge clock) begin
        wr_t  w;
        err_t e;
        int   p;
        if (we_movimento === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: addr=%0d movimento=%0d, no write expected", addr, movimento);
            end else begin
                w = wr_q.pop_front();
                check("write_addr", 32'(addr), 32'(w.a));
                check("write_movimento", 32'(movimento), 32'(w.m));
            end
        end
        if (pronto === 1'b1) begin
            if (pronto_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pronto: num_movimentos=%0d, no completion expected", num_movimentos);
            end else begin
                p = pronto_q.pop_front();
                check("pronto_num_movimentos", 32'(num_movimentos), p);
                check("pronto_erro_low", 32'(erro), 32'd0);
            end
        end
        if (erro === 1'b1 && !erro_q) begin
            if (err_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_erro: codigo_erro=%0d, no error expected", codigo_erro);
            end else begin
                e = err_q.pop_front();
                check("erro_codigo", 32'(codigo_erro), 32'(e.code));
                check("erro_num_movimentos", 32'(num_movimentos), e.num);
            end
        end
        erro_q = (erro === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("wait_state", 32'(db_estado), 32'(st));
    endtask

    task automatic start_seq(input bit check_tx);
        logic [9:0] tx_expected;
        int n;
        tx_expected = 10'b1010100100;  // 0x52 framed, bit 0 = start bit
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        if (check_tx) begin
            n = 0;
            while (saida_serial !== 1'b0 && n < 20) begin
                @(negedge clock);
                n++;
            end
            for (int i = 0; i < 10; i++) begin
                repeat ((i == 0) ? CPB / 2 : CPB) @(negedge clock);
                check($sformatf("tx_bit%0d", i), 32'(saida_serial), 32'(tx_expected[i]));
            end
        end
        wait_state(4'd3, 200);
    endtask

    task automatic check_drained(input string tag);
        repeat (10) @(negedge clock);
        check({tag, "_writes_pending"}, wr_q.size(), 0);
        check({tag, "_pronto_pending"}, pronto_q.size(), 0);
        check({tag, "_erro_pending"}, err_q.size(), 0);
    endtask

    initial begin
        int cyc;

        // Reset values while reset is held low
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_saida_serial", 32'(saida_serial), 32'd1);
        check("rst_db_estado", 32'(db_estado), 32'd0);
        check("rst_we", 32'(we_movimento), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_codigo", 32'(codigo_erro), 32'd0);
        check("rst_num", 32'(num_movimentos), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_movimento", 32'(movimento), 32'd0);
        reset = 1'b1;

        // Byte arriving while idle must be discarded
        send_byte(8'h03, 1'b1);
        check("idle_db_estado", 32'(db_estado), 32'd0);

        // Normal sequence with request-frame check
        exp_write(2'd0, 4'd3);
        exp_write(2'd1, 4'd11);
        exp_write(2'd2, 4'd0);
        pronto_q.push_back(3);
        start_seq(1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h46, 1'b1);
        check_drained("normal");
        check("normal_num_held", 32'(num_movimentos), 32'd3);
        check("normal_erro", 32'(erro), 32'd0);

        // Invalid move code
        exp_write(2'd0, 4'd2);
        exp_err(2'd1, 1);
        start_seq(1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h0C, 1'b1);
        check_drained("invalid");
        check("invalid_erro_held", 32'(erro), 32'd1);
        check("invalid_codigo_held", 32'(codigo_erro), 32'd1);

        // New start clears the error; END_BYTE first is an empty sequence
        pronto_q.push_back(0);
        start_seq(1'b0);
        check("restart_erro_cleared", 32'(erro), 32'd0);
        check("restart_codigo_cleared", 32'(codigo_erro), 32'd0);
        check("restart_num_cleared", 32'(num_movimentos), 32'd0);
        send_byte(8'h46, 1'b1);
        check_drained("empty");

        // Overflow: four moves fill memory, fifth move is rejected
        exp_write(2'd0, 4'd1);
        exp_write(2'd1, 4'd5);
        exp_write(2'd2, 4'd9);
        exp_write(2'd3, 4'd7);
        exp_err(2'd2, 4);
        start_seq(1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h09, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h05, 1'b1);
        check_drained("overflow");
        check("overflow_num", 32'(num_movimentos), 32'd4);

        // Exactly full memory followed by END_BYTE is success
        exp_write(2'd0, 4'd11);
        exp_write(2'd1, 4'd0);
        exp_write(2'd2, 4'd6);
        exp_write(2'd3, 4'd10);
        pronto_q.push_back(4);
        start_seq(1'b0);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h46, 1'b1);
        check_drained("full");

        // Framing error (stop bit low)
        exp_err(2'd1, 0);
        start_seq(1'b0);
        send_byte(8'h03, 1'b0);
        check_drained("framing");

        // Timeout: no bytes after the request
        exp_err(2'd3, 0);
        start_seq(1'b0);
        cyc = 0;
        while (erro !== 1'b1 && cyc < 1200) begin
            @(negedge clock);
            cyc++;
        end
        check("timeout_latency", cyc, 1000);
        check_drained("timeout");

        // Reset in the middle of the request frame
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (5) @(negedge clock);
        check("midreset_line_low", 32'(saida_serial), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_saida_serial", 32'(saida_serial), 32'd1);
        check("midreset_db_estado", 32'(db_estado), 32'd0);
        check("midreset_erro", 32'(erro), 32'd0);
        check("midreset_codigo", 32'(codigo_erro), 32'd0);
        reset = 1'b1;

        // Recovery after reset
        pronto_q.push_back(0);
        start_seq(1'b0);
        send_byte(8'h46, 1'b1);
        check_drained("recovery");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
